// File: rtl/spi_clkgen.sv
// SPI serial-clock and chip-select sequencer.
// Divides clk_i into SCK with one-cycle edge strobes and frames each transfer with
// NSS setup/hold delays. Optional pause support is compiled in with SPI_CLKGEN_STALL_EN.
module spi_clkgen #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned CSS_CYC   = 2,
  parameter int unsigned CSH_CYC   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 cpol_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 last_i,
  input  logic                 stall_i,
  output logic                 sck_o,
  output logic                 pos_edge_o,
  output logic                 neg_edge_o,
  output logic                 nss_o,
  output logic                 busy_o,
  output logic                 done_o
);

  // One shared down-counter serves setup, half-period and hold timing.
  localparam int unsigned CssW  = $clog2(CSS_CYC + 1);
  localparam int unsigned CshW  = $clog2(CSH_CYC + 1);
  localparam int unsigned CntW0 = (DIV_WIDTH > CssW) ? DIV_WIDTH : CssW;
  localparam int unsigned CntW  = (CntW0 > CshW) ? CntW0 : CshW;

  localparam logic [CntW-1:0] CssLoad = CntW'(CSS_CYC - 1);
  localparam logic [CntW-1:0] CshLoad = CntW'(CSH_CYC - 1);

  typedef enum logic [1:0] {StIdle, StCsSetup, StRun, StCsHold} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic                   cpol_q, cpol_d;
  logic                   sck_q, sck_d;
  logic                   pos_q, pos_d;
  logic                   neg_q, neg_d;
  logic                   nss_q, nss_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   en_q;
  logic                   stall_q, stall_d;
  logic                   stall_req;
  logic [CntW-1:0]        div_ext;
  logic                   cnt_zero;
  logic                   at_idle_lvl;
  logic                   stop_req;

`ifdef SPI_CLKGEN_STALL_EN
  assign stall_req = stall_i;
`else
  // Pause input is kept on the port but has no effect in this build.
  logic unused_stall;
  assign unused_stall = stall_i;
  assign stall_req    = 1'b0;
`endif

  assign div_ext     = CntW'(div_q);
  assign cnt_zero    = (cnt_q == '0);
  assign at_idle_lvl = (sck_q == cpol_q);
  assign stop_req    = last_i | ~en_i;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    sck_d   = sck_q;
    nss_d   = nss_q;
    stall_d = stall_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        sck_d = cpol_i;
        nss_d = 1'b1;
        if (en_i && !en_q) begin
          state_d = StCsSetup;
          div_d   = div_i;
          cpol_d  = cpol_i;
          cnt_d   = CssLoad;
          nss_d   = 1'b0;
        end
      end
      StCsSetup: begin
        if (!en_i) begin
          // Aborted before any SCK edge: go straight to the hold delay.
          state_d = StCsHold;
          cnt_d   = CshLoad;
        end else if (cnt_zero) begin
          state_d = StRun;
          cnt_d   = div_ext;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRun: begin
        if (stall_q && stall_req) begin
          // Frozen at the idle level; counter parked at a full half-period.
          cnt_d = div_ext;
          if (stop_req) begin
            state_d = StCsHold;
            cnt_d   = CshLoad;
            stall_d = 1'b0;
          end
        end else begin
          stall_d = 1'b0;
          if (cnt_zero) begin
            if (at_idle_lvl && stop_req) begin
              // Stop only at the idle level so every transfer has whole periods.
              state_d = StCsHold;
              cnt_d   = CshLoad;
            end else if (at_idle_lvl && stall_req) begin
              stall_d = 1'b1;
              cnt_d   = div_ext;
            end else begin
              sck_d = ~sck_q;
              pos_d = ~sck_q;
              neg_d = sck_q;
              cnt_d = div_ext;
            end
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StCsHold: begin
        sck_d = cpol_q;
        if (cnt_zero) begin
          state_d = StIdle;
          nss_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      sck_q   <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      nss_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      sck_q   <= sck_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      nss_q   <= nss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_i;
      stall_q <= stall_d;
    end
  end

  assign sck_o      = sck_q;
  assign pos_edge_o = pos_q;
  assign neg_edge_o = neg_q;
  assign nss_o      = nss_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_spi_clkgen.sv
// Self-checking bench for spi_clkgen: table-driven frames, random frames and
// hand-written corner sequences, all checked against a timeline model.
module tb_spi_clkgen;

  localparam int DW  = 4;
  localparam int CSS = 2;
  localparam int CSH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          cpol = 1'b0;
  logic          last = 1'b0;
  logic          stall = 1'b0;
  logic [DW-1:0] div = '0;
  logic          sck, pos, neg, nss, busy, done;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  spi_clkgen #(
    .DIV_WIDTH(DW),
    .CSS_CYC  (CSS),
    .CSH_CYC  (CSH)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .cpol_i    (cpol),
    .div_i     (div),
    .last_i    (last),
    .stall_i   (stall),
    .sck_o     (sck),
    .pos_edge_o(pos),
    .neg_edge_o(neg),
    .nss_o     (nss),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic cp;
    int   dv;
    int   np;
    bit   by_en;
    int   off;
    bit   scr;
    int   exp_pos;
    int   exp_neg;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [5:0] outs();
    return {sck, pos, neg, nss, busy, done};
  endfunction

  task automatic chk(input string nm, input int t, input logic [5:0] got, input logic [5:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got {sck,pos,neg,nss,busy,done}=%b want=%b", nm, t, got, exp);
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d want=%0d", nm, got, exp);
  endtask

  // Cycle index of the k-th SCK toggle: setup delay, then one toggle per half-period,
  // with toggles after the stall point pushed back by the frozen time.
  function automatic int tt(input int t0, input int h, input int k, input int sk, input int sh);
    return t0 + CSS + k * h + ((sk > 0 && k > sk) ? sh : 0);
  endfunction

  task automatic run_frame(input string nm, input logic cp, input int dv, input int np,
                           input bit by_en, input int off, input bit scr, input int sk,
                           input int sl, input bit rnd_stall, output int npos, output int nneg);
    int h, t0, b, e, ts, sh;
    logic s, p, n, bz;
    h = dv + 1;
`ifdef SPI_CLKGEN_STALL_EN
    sh = (sk > 0) ? sl : 0;
`else
    sh = 0;
`endif
    en = 1'b0; last = 1'b0; stall = 1'b0; cpol = cp; div = DW'(dv);
    repeat (2) begin
      tick();
      chk({nm, "/idle"}, cyc, outs(), {cp, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    en = 1'b1;
    t0 = cyc + 1;
    b  = tt(t0, h, 2 * np + 1, sk, sh);
    e  = b + CSH;
    ts = tt(t0, h, 2 * np - 1, sk, sh) + off;
    npos = 0;
    nneg = 0;
    for (int t = t0; t <= e + 3; t++) begin
      tick();
      s = cp; p = 1'b0; n = 1'b0;
      for (int k = 1; k <= 2 * np; k++) begin
        if (tt(t0, h, k, sk, sh) <= t) s = cp ^ (k % 2 == 1);
        if (tt(t0, h, k, sk, sh) == t) begin
          // Odd toggles leave the idle level.
          p = (k % 2 == 1) ? ~cp : cp;
          n = ~p;
        end
      end
      bz = (t < e);
      chk({nm, "/frame"}, cyc, outs(), {s, p, n, ~bz, bz, (t == e)});
      if (pos) npos++;
      if (neg) nneg++;
      if (t == ts) begin
        if (by_en) en = 1'b0;
        else last = 1'b1;
      end
      if (scr && t < b - 1) begin
        cpol = 1'($urandom);
        div  = DW'($urandom);
      end else begin
        cpol = cp;
        div  = DW'(dv);
      end
      if (rnd_stall) stall = 1'($urandom);
      if (sk > 0 && t == tt(t0, h, sk, sk, sh)) stall = 1'b1;
      if (sk > 0 && t == tt(t0, h, sk, sk, sh) + sl) stall = 1'b0;
    end
    en = 1'b0; last = 1'b0; stall = 1'b0;
  endtask

  initial begin
    int np_o, nn_o, t0, np, dv;
    logic cp;
    bit rs;

    vecs[0] = '{cp: 1'b0, dv: 3,  np: 8, by_en: 1'b0, off: 0, scr: 1'b0, exp_pos: 8, exp_neg: 8};
    vecs[1] = '{cp: 1'b1, dv: 0,  np: 4, by_en: 1'b0, off: 1, scr: 1'b0, exp_pos: 4, exp_neg: 4};
    vecs[2] = '{cp: 1'b0, dv: 3,  np: 4, by_en: 1'b0, off: 2, scr: 1'b1, exp_pos: 4, exp_neg: 4};
    vecs[3] = '{cp: 1'b0, dv: 3,  np: 3, by_en: 1'b1, off: 0, scr: 1'b0, exp_pos: 3, exp_neg: 3};
    vecs[4] = '{cp: 1'b1, dv: 15, np: 1, by_en: 1'b1, off: 5, scr: 1'b1, exp_pos: 1, exp_neg: 1};
    vecs[5] = '{cp: 1'b1, dv: 1,  np: 2, by_en: 1'b0, off: 3, scr: 1'b1, exp_pos: 2, exp_neg: 2};

    // Reset state.
    repeat (2) begin
      tick();
      chk("reset", cyc, outs(), 6'b000100);
    end
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_frame($sformatf("vec%0d", i), vecs[i].cp, vecs[i].dv, vecs[i].np, vecs[i].by_en,
                vecs[i].off, vecs[i].scr, 0, 0, 1'b0, np_o, nn_o);
      chk_int($sformatf("vec%0d/pos_count", i), np_o, vecs[i].exp_pos);
      chk_int($sformatf("vec%0d/neg_count", i), nn_o, vecs[i].exp_neg);
    end

`ifdef SPI_CLKGEN_STALL_EN
    rs = 1'b0;
`else
    rs = 1'b1;
`endif
    for (int r = 0; r < 12; r++) begin
      cp = 1'($urandom_range(0, 1));
      dv = $urandom_range(0, 7);
      np = $urandom_range(1, 4);
      run_frame($sformatf("rnd%0d", r), cp, dv, np, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2 * (dv + 1) - 1), 1'b1, 0, 0, rs, np_o, nn_o);
      chk_int($sformatf("rnd%0d/pos_count", r), np_o, np);
      chk_int($sformatf("rnd%0d/neg_count", r), nn_o, np);
    end

    // Stall after the 2nd falling edge: gap of 10 cycles only when the feature is built in.
    run_frame("stall", 1'b0, 1, 6, 1'b0, 0, 1'b0, 4, 10, 1'b0, np_o, nn_o);
    chk_int("stall/pos_count", np_o, 6);
    chk_int("stall/neg_count", nn_o, 6);

    // en_i dropped during chip-select setup: hold delay, done, no SCK edge.
    cpol = 1'b0; div = DW'(3);
    tick();
    en = 1'b1;
    tick();
    chk("setup_abort/t0", cyc, outs(), 6'b000010);
    en = 1'b0;
    tick();
    chk("setup_abort/t1", cyc, outs(), 6'b000010);
    tick();
    chk("setup_abort/t2", cyc, outs(), 6'b000010);
    tick();
    chk("setup_abort/done", cyc, outs(), 6'b000101);
    tick();
    chk("setup_abort/idle", cyc, outs(), 6'b000100);

    // Asynchronous reset while SCK is high.
    en = 1'b1;
    t0 = cyc + 1;
    while (cyc < t0 + CSS + 4) tick();
    chk("async_rst/pre", cyc, outs(), 6'b110010);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst/now", cyc, outs(), 6'b000100);
    en = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("async_rst/after", cyc, outs(), 6'b000100);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
